// File: rtl/level_pkg.sv
// Shared constants for the battery-level display path: level codes, LED width
// and the alarm FSM state encoding.
package level_pkg;

    localparam int LED_W = 5;

    localparam logic [2:0] LVL_CRIT = 3'd0;
    localparam logic [2:0] LVL_LOW  = 3'd1;
    localparam logic [2:0] LVL_MED  = 3'd2;
    localparam logic [2:0] LVL_HIGH = 3'd3;
    localparam logic [2:0] LVL_FULL = 3'd4;

    typedef logic [1:0] alarm_state_t;

    localparam alarm_state_t ST_IDLE     = 2'd0;
    localparam alarm_state_t ST_ALARM    = 2'd1;
    localparam alarm_state_t ST_SILENCED = 2'd2;
    localparam alarm_state_t ST_WARN     = 2'd3;

    function automatic logic [LED_W-1:0] lvl2led(input logic [2:0] code);
        return LED_W'(1) << code;
    endfunction

endpackage

// File: rtl/level_debouncer.sv
// Decodes the active-low one-hot comparator flags and commits a new level only
// after STABLE_CYCLES consecutive identical valid samples.
module level_debouncer
    import level_pkg::*;
#(
    parameter int STABLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LED_W-1:0] flags_n_i,
    output logic [2:0]       level_code_o,
    output logic             level_changed_o
);

    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   STABLE_C = CW'(STABLE_CYCLES);

    logic [LED_W-1:0] flags;
    logic             cand_valid;
    logic             cand_diff;
    logic [2:0]       cand_code;

    logic [2:0]    level_q, level_d;
    logic [2:0]    pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chg_q, chg_d;

    assign flags      = ~flags_n_i;
    assign cand_valid = $onehot(flags);
    assign cand_diff  = cand_valid && (cand_code != level_q);

    always_comb begin
        cand_code = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (flags[i]) cand_code = 3'(i);
        end
    end

    // The commit check looks at the next count so a step lands on edge N, not N+1.
    always_comb begin
        level_d = level_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        chg_d   = 1'b0;
        if (cand_diff && (cand_code == pend_q)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            pend_d = cand_code;
            cnt_d  = cand_diff ? CW'(1) : '0;
        end
        if (cnt_d == STABLE_C) begin
            level_d = pend_d;
            chg_d   = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= LVL_CRIT;
            pend_q  <= '0;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
        end
    end

    assign level_code_o    = level_q;
    assign level_changed_o = chg_q;

endmodule

// File: rtl/level_display_ctrl.sv
// Battery level display: debounced LED bar / level code plus critical alarm FSM.
// Optional LOW_WARN_EN adds a slow-blink, silent WARN state for the low level.
module level_display_ctrl
    import level_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int BLINK_DIV     = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             critic_n,
    input  logic             low_n,
    input  logic             medium_n,
    input  logic             high_n,
    input  logic             full_n,
    input  logic             ack,
    output logic [LED_W-1:0] led,
    output logic [2:0]       level_code,
    output logic             level_changed,
    output logic             alarm_led,
    output logic             buzzer
);

    localparam int            BW         = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    alarm_state_t  state_q, state_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          aled_q, aled_d;
    logic          is_crit;
    logic          blink_wrap;
`ifdef LOW_WARN_EN
    logic          phase_q, phase_d;
`endif

    level_debouncer #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_deb (
        .clk            (clk),
        .rst_n          (rst_n),
        .flags_n_i      ({full_n, high_n, medium_n, low_n, critic_n}),
        .level_code_o   (level_code),
        .level_changed_o(level_changed)
    );

    assign led        = lvl2led(level_code);
    assign is_crit    = (level_code == LVL_CRIT);
    assign blink_wrap = (blink_q == BLINK_LAST);

    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        aled_d  = aled_q;
`ifdef LOW_WARN_EN
        phase_d = phase_q;
`endif
        case (state_q)
            ST_ALARM: begin
                if (!is_crit) begin
                    state_d = ST_IDLE;
                    aled_d  = 1'b0;
                    blink_d = '0;
                end else if (ack) begin
                    state_d = ST_SILENCED;
                    aled_d  = 1'b1;
                    blink_d = '0;
                end else if (blink_wrap) begin
                    blink_d = '0;
                    aled_d  = ~aled_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
            ST_SILENCED: begin
                blink_d = '0;
                if (!is_crit) begin
                    state_d = ST_IDLE;
                    aled_d  = 1'b0;
`ifdef LOW_WARN_EN
                    if (level_code == LVL_LOW) begin
                        state_d = ST_WARN;
                        aled_d  = 1'b1;
                        phase_d = 1'b0;
                    end
`endif
                end else begin
                    aled_d = 1'b1;
                end
            end
`ifdef LOW_WARN_EN
            // Half-period is doubled by toggling only on every second counter wrap.
            ST_WARN: begin
                if (is_crit) begin
                    state_d = ST_ALARM;
                    aled_d  = 1'b1;
                    blink_d = '0;
                end else if (level_code != LVL_LOW) begin
                    state_d = ST_IDLE;
                    aled_d  = 1'b0;
                    blink_d = '0;
                end else if (blink_wrap) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                    if (phase_q) aled_d = ~aled_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
`endif
            default: begin
                aled_d  = 1'b0;
                blink_d = '0;
                state_d = ST_IDLE;
                if (is_crit) begin
                    state_d = ST_ALARM;
                    aled_d  = 1'b1;
                end
`ifdef LOW_WARN_EN
                else if (level_code == LVL_LOW) begin
                    state_d = ST_WARN;
                    aled_d  = 1'b1;
                    phase_d = 1'b0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            blink_q <= '0;
            aled_q  <= 1'b0;
`ifdef LOW_WARN_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            aled_q  <= aled_d;
`ifdef LOW_WARN_EN
            phase_q <= phase_d;
`endif
        end
    end

    assign alarm_led = aled_q;
    assign buzzer    = (state_q == ST_ALARM) && aled_q;

endmodule

// File: tb/tb_level_display_ctrl.sv
// Directed bench for level_display_ctrl with STABLE_CYCLES=4, BLINK_DIV=5.
module tb_level_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       critic_n, low_n, medium_n, high_n, full_n;
    logic       ack = 1'b0;
    logic [4:0] led;
    logic [2:0] level_code;
    logic       level_changed, alarm_led, buzzer;

    int n_chk = 0;
    int n_err = 0;
    int pulses;

    localparam logic [4:0] F_CRIT = 5'b11110;
    localparam logic [4:0] F_LOW  = 5'b11101;
    localparam logic [4:0] F_MED  = 5'b11011;
    localparam logic [4:0] F_HIGH = 5'b10111;
    localparam logic [4:0] F_FULL = 5'b01111;

    level_display_ctrl #(
        .STABLE_CYCLES(4),
        .BLINK_DIV    (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .critic_n     (critic_n),
        .low_n        (low_n),
        .medium_n     (medium_n),
        .high_n       (high_n),
        .full_n       (full_n),
        .ack          (ack),
        .led          (led),
        .level_code   (level_code),
        .level_changed(level_changed),
        .alarm_led    (alarm_led),
        .buzzer       (buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_flags(input logic [4:0] f_n);
        {full_n, high_n, medium_n, low_n, critic_n} = f_n;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            pulses += int'(level_changed);
        end
    endtask

    initial begin
        set_flags(F_FULL);
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_code", level_code, 0);
        chk("rst_led", led, 5'b00001);
        chk("rst_chg", level_changed, 0);
        chk("rst_aled", alarm_led, 0);
        chk("rst_buzz", buzzer, 0);
        rst_n = 1'b1;

        // Step to full: commit on edge 4, alarm active until then
        tick(1);
        chk("t1_alarm_aled", alarm_led, 1);
        chk("t1_alarm_buzz", buzzer, 1);
        chk("t1_code_e1", level_code, 0);
        tick(2);
        chk("t1_code_e3", level_code, 0);
        chk("t1_chg_e3", level_changed, 0);
        tick(1);
        chk("t1_code_e4", level_code, 4);
        chk("t1_led_e4", led, 5'b10000);
        chk("t1_chg_e4", level_changed, 1);
        tick(1);
        chk("t1_chg_e5", level_changed, 0);
        chk("t1_idle_aled", alarm_led, 0);
        chk("t1_idle_buzz", buzzer, 0);

        // Glitch rejection then clean commit
        set_flags(F_MED);
        tick(3);
        chk("t2_med_e3", level_code, 4);
        tick(1);
        chk("t2_med_code", level_code, 2);
        chk("t2_med_chg", level_changed, 1);
        tick(1);
        pulses = 0;
        set_flags(F_HIGH);
        run(3);
        set_flags(F_MED);
        run(2);
        chk("t2_glitch_pulses", pulses, 0);
        chk("t2_glitch_code", level_code, 2);
        set_flags(F_HIGH);
        tick(3);
        chk("t2_high_e3", level_code, 2);
        tick(1);
        chk("t2_high_code", level_code, 3);
        chk("t2_high_led", led, 5'b01000);
        chk("t2_high_chg", level_changed, 1);

        // Critical: blink 5 on / 5 off, buzzer follows
        set_flags(F_CRIT);
        tick(4);
        chk("t3_crit_code", level_code, 0);
        chk("t3_crit_led", led, 5'b00001);
        chk("t3_pre_aled", alarm_led, 0);
        tick(1);
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("t3_blink%0d", k), alarm_led, ((k / 5) % 2) == 0);
            chk($sformatf("t3_buzz%0d", k), buzzer, ((k / 5) % 2) == 0);
            tick(1);
        end

        // Silence, then leave critical
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("t4_sil_aled", alarm_led, 1);
        chk("t4_sil_buzz", buzzer, 0);
        tick(6);
        chk("t4_sil_aled2", alarm_led, 1);
        chk("t4_sil_buzz2", buzzer, 0);
        set_flags(F_LOW);
        tick(4);
        chk("t4_low_code", level_code, 1);
        chk("t4_low_chg", level_changed, 1);
        chk("t4_low_aled_sil", alarm_led, 1);
        tick(1);
        ack = 1'b1;
`ifdef LOW_WARN_EN
        for (int k = 0; k < 25; k++) begin
            chk($sformatf("t6_warn%0d", k), alarm_led, ((k / 10) % 2) == 0);
            chk($sformatf("t6_wbuzz%0d", k), buzzer, 0);
            tick(1);
        end
`else
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t4_idle%0d", k), alarm_led, 0);
            chk($sformatf("t4_ibuzz%0d", k), buzzer, 0);
            tick(1);
        end
`endif
        ack = 1'b0;

        // Invalid flag patterns must hold the committed level
        pulses = 0;
        set_flags(5'b11111);
        run(10);
        set_flags(5'b00011);
        run(10);
        chk("t5_inv_pulses", pulses, 0);
        chk("t5_inv_code", level_code, 1);
        chk("t5_inv_led", led, 5'b00010);

`ifndef LOW_WARN_EN
        set_flags(F_CRIT);
        tick(5);
        chk("t6_pre_aled", alarm_led, 1);
        chk("t6_pre_buzz", buzzer, 1);
`else
        set_flags(F_LOW);
`endif
        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_code", level_code, 0);
        chk("t6_arst_led", led, 5'b00001);
        chk("t6_arst_chg", level_changed, 0);
        chk("t6_arst_aled", alarm_led, 0);
        chk("t6_arst_buzz", buzzer, 0);
        set_flags(F_FULL);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("t6_rec_aled", alarm_led, 1);
        chk("t6_rec_buzz", buzzer, 1);
        tick(3);
        chk("t6_rec_code", level_code, 4);
        chk("t6_rec_chg", level_changed, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
